// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - ring-oscillator PUF evaluation sequencer
// Runs 2*N_BITS clear/enable/capture cycles on the PUF core and packs pairwise count compares.
module puf_eval_ctrl #(
  parameter int CNT_BIT_SIZE = 5,
  parameter int CHAL_W       = 4,
  parameter int N_BITS       = 8,
  parameter int SETTLE_CYC   = 4,
  parameter int TIMEOUT      = 255,
  parameter int TO_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [CHAL_W-1:0]       i_chal_base,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [N_BITS-1:0]       o_response,
  output logic                    o_timeout_err,
  output logic [CHAL_W-1:0]       o_puf_sel,
  output logic                    o_puf_en,
  output logic                    o_puf_rst_n,
  input  logic                    i_puf_valid,
  input  logic [CNT_BIT_SIZE-1:0] i_puf_count
);

  localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_CAPT,
    S_CMP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CHAL_W-1:0]       base_q, base_d;
  logic [CHAL_W-1:0]       sel_q, sel_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    half_q, half_d;
  logic [TO_W-1:0]         cyc_q, cyc_d;
  logic                    zero_q, zero_d;
  logic [CNT_BIT_SIZE-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_BIT_SIZE-1:0] cnt_b_q, cnt_b_d;
  logic [N_BITS-1:0]       shadow_q, shadow_d;
  logic [N_BITS-1:0]       resp_q, resp_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    en_q, en_d;
  logic                    prst_n_q, prst_n_d;
  logic [CNT_BIT_SIZE-1:0] cap_cnt;

  // A timed-out evaluation contributes a zero count to its pair.
  assign cap_cnt = zero_q ? '0 : i_puf_count;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    sel_d    = sel_q;
    k_d      = k_q;
    half_d   = half_q;
    cyc_d    = cyc_q;
    zero_d   = zero_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    shadow_d = shadow_q;
    resp_d   = resp_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d   = i_chal_base;
          err_d    = 1'b0;
          k_d      = '0;
          half_d   = 1'b0;
          cyc_d    = '0;
          shadow_d = '0;
          state_d  = S_CLR;
        end
      end
      S_CLR: begin
        if (cyc_q == TO_W'(SETTLE_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_RUN;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_RUN: begin
        if (i_puf_valid) begin
          zero_d  = 1'b0;
          state_d = S_CAPT;
        end else if (cyc_q == TO_W'(TIMEOUT - 1)) begin
          zero_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_CAPT;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_CAPT: begin
        if (!half_q) begin
          cnt_a_d = cap_cnt;
          half_d  = 1'b1;
          cyc_d   = '0;
          state_d = S_CLR;
        end else begin
          cnt_b_d = cap_cnt;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        shadow_d[k_q] = (cnt_a_q > cnt_b_q);
        if (k_q == KW'(N_BITS - 1)) begin
          resp_d  = shadow_d;
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          half_d  = 1'b0;
          cyc_d   = '0;
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // {k, half} is 2k+half, so this walks base, base+1, ... modulo 2^CHAL_W.
    if (state_d == S_CLR) begin
      sel_d = base_d + CHAL_W'({k_d, half_d});
    end

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    en_d     = (state_d == S_RUN);
    prst_n_d = (state_d != S_IDLE) && (state_d != S_CLR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      sel_q    <= '0;
      k_q      <= '0;
      half_q   <= 1'b0;
      cyc_q    <= '0;
      zero_q   <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      shadow_q <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      prst_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      sel_q    <= sel_d;
      k_q      <= k_d;
      half_q   <= half_d;
      cyc_q    <= cyc_d;
      zero_q   <= zero_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      shadow_q <= shadow_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      prst_n_q <= prst_n_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_response    = resp_q;
  assign o_timeout_err = err_q;
  assign o_puf_sel     = sel_q;
  assign o_puf_en      = en_q;
  assign o_puf_rst_n   = prst_n_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - directed self-checking bench for puf_eval_ctrl
module tb_puf_eval_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [3:0] i_chal_base;
  logic       o_busy, o_done, o_timeout_err, o_puf_en, o_puf_rst_n;
  logic [7:0] o_response;
  logic [3:0] o_puf_sel;
  logic       i_puf_valid;
  logic [4:0] i_puf_count;

  puf_eval_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_chal_base(i_chal_base),
    .o_busy(o_busy), .o_done(o_done), .o_response(o_response),
    .o_timeout_err(o_timeout_err), .o_puf_sel(o_puf_sel), .o_puf_en(o_puf_en),
    .o_puf_rst_n(o_puf_rst_n), .i_puf_valid(i_puf_valid), .i_puf_count(i_puf_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] cnt_tab [16];
  int         dly_tab [16];
  logic       never_v [16];
  int         run_len = 0;

  // PUF core model: count per oscillator, valid after dly_tab enabled cycles.
  assign i_puf_count = cnt_tab[o_puf_sel];
  always @(negedge clk) begin
    if (o_puf_rst_n === 1'b0) begin
      run_len = 0;
      i_puf_valid = 1'b0;
    end else if (o_puf_en === 1'b1) begin
      run_len = run_len + 1;
      i_puf_valid = (run_len >= dly_tab[o_puf_sel]) && !never_v[o_puf_sel];
    end
  end

  int         busy_cnt, done_cnt, completed;
  logic [7:0] resp_at_done;
  logic       err_first;
  logic [3:0] sel_seq [$];
  int         low_seq [$];

  task automatic set_pattern(input int mode);
    for (int i = 0; i < 16; i++) begin
      dly_tab[i] = 3;
      never_v[i] = 1'b0;
      case (mode)
        0: cnt_tab[i] = (i % 2 == 0) ? 5'd20 : 5'd10;
        1: cnt_tab[i] = 5'd17;
        default: cnt_tab[i] = (((i / 2) % 2 == 0) == (i % 2 == 0)) ? 5'd20 : 5'd10;
      endcase
    end
  endtask

  task automatic start_run(input logic [3:0] b);
    @(negedge clk);
    i_start = 1'b1;
    i_chal_base = b;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic watch(input int limit);
    int   low_run;
    logic prev_en;
    busy_cnt = 0; done_cnt = 0; completed = 0;
    low_run = 0; prev_en = 1'b0;
    sel_seq.delete(); low_seq.delete();
    err_first = o_timeout_err;
    for (int c = 0; c < limit; c++) begin
      if (!o_busy) begin
        completed = 1;
        break;
      end
      busy_cnt++;
      if (o_done) begin
        done_cnt++;
        resp_at_done = o_response;
      end
      if (!o_puf_rst_n) low_run++;
      if (o_puf_en && !prev_en) begin
        sel_seq.push_back(o_puf_sel);
        low_seq.push_back(low_run);
      end
      if (o_puf_rst_n) low_run = 0;
      prev_en = o_puf_en;
      @(negedge clk);
    end
    checks++;
    if (completed != 1) begin
      errors++;
      $display("FAIL run_complete: busy still high after %0d cycles", limit);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_start = 1'b0; i_chal_base = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_timeout_err, o_puf_en, o_puf_rst_n} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {o_busy, o_done, o_timeout_err, o_puf_en, o_puf_rst_n});
    end
    checks++;
    if (o_response !== 8'h00 || o_puf_sel !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: resp=%h sel=%h want 00/0", o_response, o_puf_sel);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_ones;
    set_pattern(0);
    start_run(4'h0);
    watch(3000);
    checks++;
    if (resp_at_done !== 8'hFF) begin errors++; $display("FAIL ones_resp: got %h want ff", resp_at_done); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL ones_done_pulse: got %0d cycles want 1", done_cnt); end
    checks++;
    if (busy_cnt !== 137) begin errors++; $display("FAIL ones_latency: got %0d want 137", busy_cnt); end
    checks++;
    if (o_response !== 8'hFF || o_done !== 1'b0 || o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL ones_idle: resp=%h done=%b err=%b want ff/0/0", o_response, o_done, o_timeout_err);
    end
  endtask

  task automatic test_tie_and_alt;
    set_pattern(1);
    start_run(4'h0);
    watch(3000);
    checks++;
    if (resp_at_done !== 8'h00) begin errors++; $display("FAIL tie_resp: got %h want 00", resp_at_done); end
    set_pattern(2);
    start_run(4'h0);
    watch(3000);
    checks++;
    if (resp_at_done !== 8'h55) begin errors++; $display("FAIL alt_resp: got %h want 55", resp_at_done); end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_sel;
    set_pattern(0);
    start_run(4'hE);
    watch(3000);
    checks++;
    if (sel_seq.size() !== 16) begin errors++; $display("FAIL wrap_evals: got %0d want 16", sel_seq.size()); end
    for (int i = 0; i < sel_seq.size(); i++) begin
      exp_sel = 4'hE + 4'(i);
      checks++;
      if (sel_seq[i] !== exp_sel) begin
        errors++; $display("FAIL wrap_sel[%0d]: got %h want %h", i, sel_seq[i], exp_sel);
      end
      checks++;
      if (low_seq[i] !== 4) begin
        errors++; $display("FAIL settle_len[%0d]: got %0d want 4", i, low_seq[i]);
      end
    end
    checks++;
    if (resp_at_done !== 8'hFF) begin errors++; $display("FAIL wrap_resp: got %h want ff", resp_at_done); end
  endtask

  task automatic test_timeout;
    set_pattern(0);
    dly_tab[6] = 255;
    start_run(4'h0);
    watch(3000);
    checks++;
    if (o_timeout_err !== 1'b0 || resp_at_done !== 8'hFF) begin
      errors++; $display("FAIL valid_last_cycle: err=%b resp=%h want 0/ff", o_timeout_err, resp_at_done);
    end
    checks++;
    if (busy_cnt !== 389) begin errors++; $display("FAIL valid_last_latency: got %0d want 389", busy_cnt); end

    set_pattern(0);
    never_v[6] = 1'b1;
    start_run(4'h0);
    watch(3000);
    checks++;
    if (o_timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", o_timeout_err); end
    checks++;
    if (resp_at_done !== 8'hF7) begin errors++; $display("FAIL timeout_resp: got %h want f7", resp_at_done); end
    checks++;
    if (busy_cnt !== 389) begin errors++; $display("FAIL timeout_latency: got %0d want 389", busy_cnt); end

    set_pattern(0);
    start_run(4'h0);
    watch(3000);
    checks++;
    if (err_first !== 1'b0 || o_timeout_err !== 1'b0) begin
      errors++; $display("FAIL err_clear: start=%b end=%b want 0/0", err_first, o_timeout_err);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    set_pattern(2);
    start_run(4'h0);
    fork
      watch(3000);
      begin
        repeat (20) @(negedge clk);
        i_start = 1'b1; i_chal_base = 4'h9;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_response !== 8'hFF) begin errors++; $display("FAIL busy_resp_hold: got %h want ff", o_response); end
        n = 0;
        while (o_done !== 1'b1 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
      end
    join
    checks++;
    if (sel_seq.size() !== 16 || sel_seq[0] !== 4'h0 || sel_seq[15] !== 4'hF) begin
      errors++; $display("FAIL busy_start_ignored: evals=%0d first=%h want 16/0", sel_seq.size(), sel_seq[0]);
    end
    checks++;
    if (resp_at_done !== 8'h55 || done_cnt !== 1) begin
      errors++; $display("FAIL busy_resp: got %h/%0d want 55/1", resp_at_done, done_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored: busy=%b want 0", o_busy); end
  endtask

  task automatic test_reset_mid_run;
    int dseen;
    set_pattern(0);
    never_v[0] = 1'b1;
    start_run(4'h0);
    repeat (270) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1 || o_timeout_err !== 1'b1) begin
      errors++; $display("FAIL pre_reset: busy=%b err=%b want 1/1", o_busy, o_timeout_err);
    end
    rst_n = 1'b0;
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) dseen++;
    end
    checks++;
    if ({o_busy, o_done, o_timeout_err, o_puf_en, o_puf_rst_n} !== 5'b00000 || o_response !== 8'h00 || o_puf_sel !== 4'h0) begin
      errors++;
      $display("FAIL midrun_reset: ctrl=%b resp=%h sel=%h want 00000/00/0",
               {o_busy, o_done, o_timeout_err, o_puf_en, o_puf_rst_n}, o_response, o_puf_sel);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (o_done) dseen++;
    end
    checks++;
    if (dseen !== 0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL midrun_no_done: done_seen=%0d busy=%b want 0/0", dseen, o_busy);
    end
    set_pattern(0);
    start_run(4'h3);
    watch(3000);
    checks++;
    if (resp_at_done !== 8'h00) begin errors++; $display("FAIL post_reset_resp: got %h want 00", resp_at_done); end
  endtask

  initial begin
    i_puf_valid = 1'b0;
    set_pattern(0);
    test_reset();
    test_all_ones();
    test_tie_and_alt();
    test_wrap();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
